// File: rtl/uart_cmd_responder_pkg.sv
// Shared command/reply codes and state encodings for the uart2flash device-side responder.
package uart_cmd_responder_pkg;

  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] RspAck   = 8'h06;
  localparam logic [7:0] RspNak   = 8'h15;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StMem,
    StReply
  } frame_state_e;

  typedef enum logic [1:0] {
    SndIdle,
    SndSend,
    SndWaitHi,
    SndWaitLo
  } send_state_e;

  function automatic logic isCmd(input logic [7:0] b);
    return (b == CmdRead) || (b == CmdWrite);
  endfunction

endpackage

// File: rtl/uart_reply_sender.sv
// Streams a one- or two-byte reply into the UART transmitter (SEND/WAIT_HI/WAIT_LO).
module uart_reply_sender
  import uart_cmd_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] replyBuf,
  input  logic [1:0]  replyLen,
  input  logic        load,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        done
);

  send_state_e stateQ, stateD;
  logic [7:0]  dataQ, dataD;
  logic [7:0]  loQ, loD;
  logic        moreQ, moreD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= SndIdle;
      dataQ  <= 8'h00;
      loQ    <= 8'h00;
      moreQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      dataQ  <= dataD;
      loQ    <= loD;
      moreQ  <= moreD;
    end
  end

  always_comb begin
    stateD   = stateQ;
    dataD    = dataQ;
    loD      = loQ;
    moreD    = moreQ;
    tx_start = 1'b0;
    done     = 1'b0;
    unique case (stateQ)
      SndIdle: begin
        // First byte always comes from the high half of the buffer.
        if (load) begin
          dataD  = replyBuf[15:8];
          loD    = replyBuf[7:0];
          moreD  = (replyLen == 2'd2);
          stateD = SndSend;
        end
      end
      SndSend: begin
        tx_start = 1'b1;
        stateD   = SndWaitHi;
      end
      SndWaitHi: begin
        if (tx_busy) stateD = SndWaitLo;
      end
      SndWaitLo: begin
        if (!tx_busy) begin
          if (moreQ) begin
            dataD  = loQ;
            moreD  = 1'b0;
            stateD = SndSend;
          end else begin
            done   = 1'b1;
            stateD = SndIdle;
          end
        end
      end
      default: stateD = SndIdle;
    endcase
  end

  assign tx_data = dataQ;

endmodule

// File: rtl/uart_cmd_responder.sv
// Device-side uart2flash responder: decodes host read/write frames, runs one flash-word
// access, and hands the reply to uart_reply_sender.
module uart_cmd_responder
  import uart_cmd_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned TIMEOUT = 2500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              frame_err,
  output logic              idle
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  frame_state_e      stateQ, stateD;
  logic              weQ, weD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic [15:0]       wdataQ, wdataD;
  logic [1:0]        byteCntQ, byteCntD;
  logic [CntW-1:0]   toCntQ, toCntD;
  logic              frameErrQ, frameErrD;

  logic              load;
  logic [15:0]       replyBuf;
  logic [1:0]        replyLen;
  logic              sendDone;
  logic              timedOut;
  logic              inFrame;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ    <= StIdle;
      weQ       <= 1'b0;
      addrQ     <= '0;
      wdataQ    <= 16'h0000;
      byteCntQ  <= 2'd0;
      toCntQ    <= '0;
      frameErrQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      weQ       <= weD;
      addrQ     <= addrD;
      wdataQ    <= wdataD;
      byteCntQ  <= byteCntD;
      toCntQ    <= toCntD;
      frameErrQ <= frameErrD;
    end
  end

  assign inFrame  = (stateQ == StAddr) || (stateQ == StData);
  assign timedOut = (toCntQ == CntLast);

  // Inter-byte timer: runs only mid-frame, cleared by any byte, saturates at the limit.
  always_comb begin
    toCntD = toCntQ;
    if (rx_valid || !inFrame) begin
      toCntD = '0;
    end else if (!timedOut) begin
      toCntD = toCntQ + CntW'(1);
    end
  end

  always_comb begin
    stateD    = stateQ;
    weD       = weQ;
    addrD     = addrQ;
    wdataD    = wdataQ;
    byteCntD  = byteCntQ;
    frameErrD = 1'b0;
    load      = 1'b0;
    replyBuf  = 16'h0000;
    replyLen  = 2'd1;
    unique case (stateQ)
      StIdle: begin
        if (rx_valid) begin
          if (isCmd(rx_data)) begin
            weD      = (rx_data == CmdWrite);
            byteCntD = 2'd0;
            stateD   = StAddr;
          end else begin
            load     = 1'b1;
            replyBuf = {RspNak, 8'h00};
            replyLen = 2'd1;
            stateD   = StReply;
          end
        end
      end
      StAddr: begin
        if (rx_valid) begin
          // Three shifts flush the register, leaving the low ADDR_W bits of {A2,A1,A0}.
          addrD    = {addrQ[ADDR_W-9:0], rx_data};
          byteCntD = byteCntQ + 2'd1;
          if (byteCntQ == 2'd2) begin
            byteCntD = 2'd0;
            stateD   = weQ ? StData : StMem;
          end
        end else if (timedOut) begin
          frameErrD = 1'b1;
          stateD    = StIdle;
        end
      end
      StData: begin
        if (rx_valid) begin
          wdataD   = {wdataQ[7:0], rx_data};
          byteCntD = byteCntQ + 2'd1;
          if (byteCntQ == 2'd1) begin
            byteCntD = 2'd0;
            stateD   = StMem;
          end
        end else if (timedOut) begin
          frameErrD = 1'b1;
          stateD    = StIdle;
        end
      end
      StMem: begin
        if (rx_valid) frameErrD = 1'b1;
        if (mem_ack) begin
          load = 1'b1;
          if (weQ) begin
            replyBuf = {RspAck, 8'h00};
            replyLen = 2'd1;
          end else begin
            replyBuf = mem_rdata;
            replyLen = 2'd2;
          end
          stateD = StReply;
        end
      end
      StReply: begin
        if (rx_valid) frameErrD = 1'b1;
        if (sendDone) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  uart_reply_sender u_sender (
    .clk      (clk),
    .rst      (rst),
    .replyBuf (replyBuf),
    .replyLen (replyLen),
    .load     (load),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .done     (sendDone)
  );

  assign mem_req   = (stateQ == StMem);
  assign mem_we    = weQ;
  assign mem_addr  = addrQ;
  assign mem_wdata = wdataQ;
  assign frame_err = frameErrQ;
  assign idle      = (stateQ == StIdle);

endmodule
